// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and parity mode encodings.
// Also intended for the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Write-side handshake into the UART transmit framer FIFO.
interface uart_tx_framer_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full/empty/level come straight from registers.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign level    = wptr_q - rptr_q;
    assign full     = (level == FULL_LEVEL);
    assign empty    = (wptr_q == rptr_q);
    // Full is checked without regard to a same-cycle pop: no write bypass.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: FIFO-buffered words serialised as start, data (LSB first),
// optional parity and stop bits, with an internal baud divider on the system clock.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    uart_tx_framer_if.slave               in_if,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = $clog2(DATA_BITS + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 eof_q, eof_d;
    logic                 done_q;

    logic                 fifo_full, fifo_empty, pop;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 baud_last, can_load;

    assign in_if.in_ready = !fifo_full;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_if.in_valid),
        .push_data (in_if.in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign baud_last = (baud_q == BAUD_LAST);
    assign can_load  = en && !fifo_empty;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pop     = 1'b0;
        eof_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (can_load) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (baud_last) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (baud_last) begin
                    state_d = StStop;
                    idx_d   = '0;
                end
            end
            StStop: begin
                if (baud_last) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == STOP_LAST) begin
                        eof_d = 1'b1;
                        if (can_load) begin
                            pop     = 1'b1;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            shreg_d = fifo_data;
            par_d   = (PARITY == PAR_ODD) ? ~^fifo_data : ^fifo_data;
        end
    end

    assign baud_d = (state_q == StIdle || baud_last) ? '0 : baud_q + 1'b1;

    // The line is driven from the current state, so tx/busy trail the FSM by one cycle.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shreg_q[0];
            StParity: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= (state_q != StIdle);
            eof_q   <= eof_d;
            done_q  <= eof_q;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer across four parameter sets; frames are
// rebuilt from the written words and compared bit-by-bit with the sampled line.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [8:0] wdata;
    logic [3:0] vld;
    logic [3:0] tx_w, busy_w, done_w, rdy_w;
    logic [2:0] lvl0, lvl1, lvl2, lvl3;

    int cur;
    logic       tx_s, busy_s, done_s, rdy_s;
    logic [2:0] lvl_s;

    int db_a  [4] = '{8, 7, 8, 5};
    int par_a [4] = '{0, 2, 1, 0};
    int sb_a  [4] = '{1, 2, 1, 1};
    int cpb_a [4] = '{16, 16, 4, 2};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_edge  = 0;
    int start_cyc = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_framer_if #(.DATA_BITS(8)) if0 ();
    uart_tx_framer_if #(.DATA_BITS(7)) if1 ();
    uart_tx_framer_if #(.DATA_BITS(8)) if2 ();
    uart_tx_framer_if #(.DATA_BITS(5)) if3 ();

    assign if0.in_valid = vld[0];
    assign if1.in_valid = vld[1];
    assign if2.in_valid = vld[2];
    assign if3.in_valid = vld[3];
    assign if0.in_data  = wdata[7:0];
    assign if1.in_data  = wdata[6:0];
    assign if2.in_data  = wdata[7:0];
    assign if3.in_data  = wdata[4:0];
    assign rdy_w = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};

    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1),
                     .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_if(if0), .tx(tx_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .fifo_level(lvl0));
    uart_tx_framer #(.DATA_BITS(7), .CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(2),
                     .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_if(if1), .tx(tx_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .fifo_level(lvl1));
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1),
                     .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_if(if2), .tx(tx_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .fifo_level(lvl2));
    uart_tx_framer #(.DATA_BITS(5), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1),
                     .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_if(if3), .tx(tx_w[3]), .busy(busy_w[3]),
        .done(done_w[3]), .fifo_level(lvl3));

    always_comb begin
        tx_s   = tx_w[cur[1:0]];
        busy_s = busy_w[cur[1:0]];
        done_s = done_w[cur[1:0]];
        rdy_s  = rdy_w[cur[1:0]];
        case (cur[1:0])
            2'd0:    lvl_s = lvl0;
            2'd1:    lvl_s = lvl1;
            2'd2:    lvl_s = lvl2;
            default: lvl_s = lvl3;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_s === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic int frame_len();
        return 1 + db_a[cur] + ((par_a[cur] != 0) ? 1 : 0) + sb_a[cur];
    endfunction

    // Line image of one frame, bit 0 first on the wire.
    function automatic logic [15:0] frame_bits(input logic [8:0] w);
        logic [15:0] f;
        int          n;
        logic        p;
        f = '0;
        n = 1;
        p = 1'b0;
        for (int i = 0; i < db_a[cur]; i++) begin
            f[n] = w[i];
            p    = p ^ w[i];
            n++;
        end
        if (par_a[cur] == 1) begin
            f[n] = ~p;
            n++;
        end else if (par_a[cur] == 2) begin
            f[n] = p;
            n++;
        end
        for (int i = 0; i < sb_a[cur]; i++) begin
            f[n] = 1'b1;
            n++;
        end
        return f;
    endfunction

    // Entered and left on a falling edge; presents the word for one rising edge.
    task automatic write_word(input logic [8:0] w, output bit acc);
        wdata          = w;
        vld[cur[1:0]]  = 1'b1;
        acc            = (rdy_s === 1'b1);
        if (acc) begin
            exp_q.push_back(frame_bits(w));
            wr_edge = cyc + 1;
        end
        @(negedge clk);
        vld[cur[1:0]] = 1'b0;
    endtask

    task automatic rx_frame(input string tag, output int gap);
        logic [15:0] got;
        logic [15:0] want;
        bit          ok;
        logic        v;
        int          n;
        int          cpb;
        n   = frame_len();
        cpb = cpb_a[cur];
        got = '0;
        ok  = 1'b1;
        gap = 0;
        @(negedge clk);
        while (tx_s !== 1'b0 && gap < 5000) begin
            @(negedge clk);
            gap++;
        end
        if (tx_s !== 1'b0) begin
            check({tag, "_start_timeout"}, tx_s, 1'b0);
            return;
        end
        start_cyc = cyc;
        for (int b = 0; b < n; b++) begin
            v      = tx_s;
            got[b] = v;
            if (busy_s !== 1'b1) ok = 1'b0;
            for (int c = 1; c < cpb; c++) begin
                @(negedge clk);
                if (tx_s !== v || busy_s !== 1'b1) ok = 1'b0;
            end
            if (b != n - 1) @(negedge clk);
        end
        want = 16'hxxxx;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        check({tag, "_bits"}, got, want);
        check({tag, "_width_busy"}, ok, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit acc5 [5];
        int g1, g2, d0, low_cnt, tries;

        rst_n = 1'b0;
        en    = 1'b0;
        vld   = '0;
        wdata = '0;
        cur   = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cur = i;
            #1;
            check("rst_tx", tx_s, 1'b1);
            check("rst_busy", busy_s, 1'b0);
            check("rst_done", done_s, 1'b0);
            check("rst_level", lvl_s, 3'd0);
            check("rst_ready", rdy_s, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 latency, bit order and done timing
        cur = 0;
        en  = 1'b1;
        d0  = done_cnt;
        fork
            begin
                write_word(9'h0A5, acc);
                check("t1_level_after_write", lvl_s, 3'd1);
                @(negedge clk);
                check("t1_level_after_pop", lvl_s, 3'd0);
                check("t1_tx_before_start", tx_s, 1'b1);
            end
            rx_frame("t1", g1);
        join
        check("t1_latency", start_cyc - wr_edge, 2);
        repeat (2) @(negedge clk);
        check("t1_done_cycle", done_cyc - start_cyc, 160);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_busy_idle", busy_s, 1'b0);

        // 7E2 frame
        cur = 1;
        fork
            write_word(9'h041, acc);
            rx_frame("t2", g1);
        join
        repeat (2) @(negedge clk);
        check("t2_frame_cycles", done_cyc - start_cyc, 176);

        // odd parity, back-to-back frames
        cur = 2;
        d0  = done_cnt;
        fork
            begin
                write_word(9'h000, acc);
                write_word(9'h0FF, acc);
            end
            begin
                rx_frame("t3a", g1);
                rx_frame("t3b", g2);
            end
        join
        check("t3_gap", g2, 0);
        repeat (3) @(negedge clk);
        check("t3_done_count", done_cnt - d0, 2);
        check("t3_busy_idle", busy_s, 1'b0);

        // fill with en low, fifth write refused, then drain
        cur = 0;
        en  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            write_word(9'(8'h30 + i), acc);
            acc5[i] = acc;
        end
        check("t4_fourth_accepted", acc5[3], 1'b1);
        check("t4_fifth_rejected", acc5[4], 1'b0);
        check("t4_level_full", lvl_s, 3'd4);
        check("t4_ready_low", rdy_s, 1'b0);
        check("t4_no_start_while_disabled", tx_s, 1'b1);
        en = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) rx_frame("t4", g1);
        low_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_s !== 1'b1) low_cnt++;
        end
        check("t4_no_extra_frame", low_cnt, 0);
        check("t4_done_count", done_cnt - d0, 4);

        // reset in the middle of a data bit
        write_word(9'h011, acc);
        write_word(9'h022, acc);
        write_word(9'h033, acc);
        tries = 0;
        while (tx_s !== 1'b0 && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        repeat (16 + 16 * 3 + 8) @(negedge clk);
        check("t5_busy_mid_frame", busy_s, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", tx_s, 1'b1);
        check("t5_rst_busy", busy_s, 1'b0);
        check("t5_rst_level", lvl_s, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        low_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_s !== 1'b1) low_cnt++;
        end
        check("t5_idle_after_reset", low_cnt, 0);
        fork
            write_word(9'h03C, acc);
            rx_frame("t5_after", g1);
        join

        // fast baud, 5-bit words, continuous writes
        cur = 3;
        fork
            for (int i = 0; i < 8; i++) begin
                tries = 0;
                do begin
                    write_word(9'((i * 7 + 3) & 31), acc);
                    tries++;
                end while (!acc && tries < 200);
            end
            for (int i = 0; i < 8; i++) rx_frame("t6", g1);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit framer with an internal baud-rate divider and a small transmit FIFO. It serialises DATA_BITS-wide words, LSB first, into a start bit, data bits, an optional parity bit and one or two stop bits. It replaces the fixed 8N1 transmitter and its external baud-clock dependency: it runs on the system clock and buffers words so that back-to-back frames leave no idle gap. It sits between the command/response logic and the board TX pin.

## Interface
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16: system clocks per bit period; must be ≥ 2.
- PARITY, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, ≥ 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enables starting new frames; does not affect FIFO writes.
- in_valid  in  1  write request for in_data.
- in_ready  out  1  FIFO not full; a write occurs when in_valid && in_ready.
- in_data  in  DATA_BITS  word to transmit.
- tx  out  1  serial line; registered output, idles high.
- busy  out  1  a frame is being shifted out.
- done  out  1  one-cycle pulse after each completed frame.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

## Operation
- Reset values (applied asynchronously while rst_n = 0): tx = 1, busy = 0, done = 0, fifo_level = 0, in_ready = 1, state = IDLE, FIFO empty.
- FIFO:
  - in_ready = !full, driven from registered state with no bypass. A write into a full FIFO is therefore never accepted, including on a cycle where a pop also occurs.
  - A pop occurs when the FSM loads a word. Push and pop may happen on the same cycle; fifo_level is then unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when en && !empty. The word is popped into the shift register and the parity bit is computed from it.
  - START → DATA after one bit period.
  - DATA → PARITY (PARITY ≠ 0) or → STOP after DATA_BITS bit periods.
  - PARITY → STOP after one bit period.
  - STOP lasts STOP_BITS bit periods. It then goes to START, popping the next word, if en && !empty; otherwise it goes to IDLE.
- Bit values: start = 0, data LSB first, parity, stop = 1.
  - Odd parity: data XOR parity bit has odd weight.
  - Even parity: data XOR parity bit has even weight.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
  - Reloads to 0 on every bit boundary and in IDLE.
  - Every bit is held for exactly CLKS_PER_BIT cycles.
- Bit index counter: $clog2(DATA_BITS+1) bits; reset on entry to DATA.
- en deasserted mid-frame: the current frame completes normally. No further pops occur until en returns.
- rst_n asserted mid-frame: the frame is aborted, tx returns to 1 immediately and buffered words are discarded.

## Timing
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Write-to-line latency with an empty FIFO in IDLE:
  - Write accepted at edge t; fifo_level = 1 after t.
  - Pop at edge t+1.
  - tx falls at edge t+2.
- busy is high from the first start-bit cycle to the last stop-bit cycle. It stays high across back-to-back frames.
- done pulses for one cycle after the last stop-bit cycle. With back-to-back frames, this is the same cycle as the first start-bit cycle of the next frame.
- Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.

## Structure
- Shared package uart_pkg holds:
  - state enum uart_tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
- The package is reused by the future receiver.
- Sub-module: sync_fifo (parameters WIDTH, DEPTH; async active-low reset; full, empty and level outputs). The framer owns the FSM, baud counter and shift register.

## Test plan
- Defaults, write 0xA5 with en = 1 → tx low at t+2, then bits 1,0,1,0,0,1,0,1, then stop bit. Each bit is 16 cycles; done pulses at cycle t+2+160.
- PARITY = 2, STOP_BITS = 2, DATA_BITS = 7, write 0x41 → 11-bit frame 0,1000001,0,1,1. Total 176 cycles.
- PARITY = 1, write 0x00 and 0xFF back-to-back → parity bits 1 and 1; no idle cycle between frames; busy stays high; two done pulses.
- Write 5 words with en = 0 → in_ready drops after the 4th write, the 5th is not accepted and fifo_level = 4. Raise en → exactly 4 frames are sent.
- Pulse rst_n low in the middle of a data bit → tx = 1, busy = 0 and fifo_level = 0 immediately. No frame is sent after release until a new write.
- CLKS_PER_BIT = 2, DATA_BITS = 5, continuous writes → every bit is exactly 2 cycles wide and FIFO ordering is preserved.
